// File: rtl/dsp_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_stream
// Brief    : Streaming valid/ready multiply-accumulate with FIRST/LAST framing
//            and a registered shift/round/saturate result path. Define
//            DSP_MAC_STREAM_OVF_EN to add the ACC_OVF status port.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_stream #(
    parameter int A_WIDTH     = 20,
    parameter int B_WIDTH     = 18,
    parameter int ACC_WIDTH   = 48,
    parameter int Z_WIDTH     = 38,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [A_WIDTH-1:0]     A,
    input  logic [B_WIDTH-1:0]     B,
    input  logic                   UNSIGNED_A,
    input  logic                   UNSIGNED_B,
    input  logic                   SUBTRACT,
    input  logic                   FIRST,
    input  logic                   LAST,
    input  logic [SHIFT_WIDTH-1:0] SHIFT_RIGHT,
    input  logic                   ROUND,
    input  logic                   SATURATE,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
`ifdef DSP_MAC_STREAM_OVF_EN
    output logic                   ACC_OVF,
`endif
    output logic [Z_WIDTH-1:0]     Z
);

    localparam int c_prod_w = A_WIDTH + B_WIDTH + 2;
    localparam logic signed [ACC_WIDTH:0] c_sat_smax = {{(ACC_WIDTH-Z_WIDTH+2){1'b0}}, {(Z_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_sat_smin = {{(ACC_WIDTH-Z_WIDTH+2){1'b1}}, {(Z_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] c_sat_umax = {{(ACC_WIDTH-Z_WIDTH+1){1'b0}}, {Z_WIDTH{1'b1}}};

    generate
        if (ACC_WIDTH < A_WIDTH + B_WIDTH + 1) begin : g_acc_width_check
            $fatal(1, "dsp_mac_stream: ACC_WIDTH must be >= A_WIDTH+B_WIDTH+1");
        end
        if (Z_WIDTH > ACC_WIDTH) begin : g_z_width_check
            $fatal(1, "dsp_mac_stream: Z_WIDTH must be <= ACC_WIDTH");
        end
    endgenerate

    // A full output register that the consumer refuses freezes the whole pipe.
    logic w_stall;
    assign w_stall  = OUT_VALID && !OUT_READY;
    assign IN_READY = !RESET && !w_stall;

    logic                   r_s1_valid, r_s1_ua, r_s1_ub, r_s1_sub, r_s1_first, r_s1_last;
    logic                   r_s1_round, r_s1_sat;
    logic [A_WIDTH-1:0]     r_s1_a;
    logic [B_WIDTH-1:0]     r_s1_b;
    logic [SHIFT_WIDTH-1:0] r_s1_shift;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= IN_VALID;
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_ua    <= UNSIGNED_A;
            r_s1_ub    <= UNSIGNED_B;
            r_s1_sub   <= SUBTRACT;
            r_s1_first <= FIRST;
            r_s1_last  <= LAST;
            r_s1_shift <= SHIFT_RIGHT;
            r_s1_round <= ROUND;
            r_s1_sat   <= SATURATE;
        end
    end

    logic signed [A_WIDTH:0]    w_a_ext;
    logic signed [B_WIDTH:0]    w_b_ext;
    logic signed [c_prod_w-1:0] w_prod;
    assign w_a_ext = $signed({r_s1_ua ? 1'b0 : r_s1_a[A_WIDTH-1], r_s1_a});
    assign w_b_ext = $signed({r_s1_ub ? 1'b0 : r_s1_b[B_WIDTH-1], r_s1_b});
    assign w_prod  = c_prod_w'(w_a_ext) * c_prod_w'(w_b_ext);

    logic                        r_s2_valid, r_s2_uns, r_s2_sub, r_s2_first, r_s2_last;
    logic                        r_s2_round, r_s2_sat;
    logic signed [ACC_WIDTH-1:0] r_s2_prod;
    logic [SHIFT_WIDTH-1:0]      r_s2_shift;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s2_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= ACC_WIDTH'(w_prod);
            r_s2_uns   <= r_s1_ua && r_s1_ub;
            r_s2_sub   <= r_s1_sub;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_shift <= r_s1_shift;
            r_s2_round <= r_s1_round;
            r_s2_sat   <= r_s1_sat;
        end
    end

    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_base, w_acc_next;
    logic                        r_s3_valid, r_s3_last, r_s3_uns, r_s3_round, r_s3_sat;
    logic [SHIFT_WIDTH-1:0]      r_s3_shift;
    assign w_acc_base = r_s2_first ? '0 : r_acc;
    assign w_acc_next = r_s2_sub ? (w_acc_base - r_s2_prod) : (w_acc_base + r_s2_prod);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s3_valid <= 1'b0;
            r_acc      <= '0;
        end else if (!w_stall) begin
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_uns   <= r_s2_uns;
            r_s3_shift <= r_s2_shift;
            r_s3_round <= r_s2_round;
            r_s3_sat   <= r_s2_sat;
            if (r_s2_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

`ifdef DSP_MAC_STREAM_OVF_EN
    logic w_step_ovf, r_acc_ovf;
    assign w_step_ovf = (w_acc_next[ACC_WIDTH-1] != w_acc_base[ACC_WIDTH-1]) &&
                        (r_s2_sub ? (w_acc_base[ACC_WIDTH-1] != r_s2_prod[ACC_WIDTH-1])
                                  : (w_acc_base[ACC_WIDTH-1] == r_s2_prod[ACC_WIDTH-1]));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc_ovf <= 1'b0;
        end else if (!w_stall && r_s2_valid) begin
            r_acc_ovf <= (r_s2_first ? 1'b0 : r_acc_ovf) | w_step_ovf;
        end
    end
`endif

    // Shifting by one less than requested exposes the rounding bit as bit 0;
    // the final one-bit shift then costs nothing.
    logic signed [ACC_WIDTH-1:0] w_pre;
    logic [ACC_WIDTH:0]          w_sr_sum;
    assign w_pre    = r_acc >>> (r_s3_shift - SHIFT_WIDTH'(1));
    assign w_sr_sum = (r_s3_shift == '0) ? {r_acc[ACC_WIDTH-1], r_acc}
                    : ({{2{w_pre[ACC_WIDTH-1]}}, w_pre[ACC_WIDTH-1:1]} +
                       {{ACC_WIDTH{1'b0}}, r_s3_round & w_pre[0]});

    logic               r_sr_valid, r_sr_uns, r_sr_sat;
    logic [ACC_WIDTH:0] r_sr_val;
`ifdef DSP_MAC_STREAM_OVF_EN
    logic               r_sr_ovf;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sr_valid <= 1'b0;
        end else if (!w_stall) begin
            r_sr_valid <= r_s3_valid && r_s3_last;
            r_sr_val   <= w_sr_sum;
            r_sr_uns   <= r_s3_uns;
            r_sr_sat   <= r_s3_sat;
`ifdef DSP_MAC_STREAM_OVF_EN
            r_sr_ovf   <= r_acc_ovf;
`endif
        end
    end

    logic               w_hi, w_lo;
    logic [Z_WIDTH-1:0] w_z_next;
    assign w_hi = r_sr_uns ? ($signed(r_sr_val) > c_sat_umax) : ($signed(r_sr_val) > c_sat_smax);
    assign w_lo = r_sr_uns ? r_sr_val[ACC_WIDTH] : ($signed(r_sr_val) < c_sat_smin);

    always_comb begin
        w_z_next = r_sr_val[Z_WIDTH-1:0];
        if (r_sr_sat && w_hi) begin
            w_z_next = r_sr_uns ? c_sat_umax[Z_WIDTH-1:0] : c_sat_smax[Z_WIDTH-1:0];
        end else if (r_sr_sat && w_lo) begin
            w_z_next = r_sr_uns ? '0 : c_sat_smin[Z_WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            Z         <= '0;
`ifdef DSP_MAC_STREAM_OVF_EN
            ACC_OVF   <= 1'b0;
`endif
        end else if (!w_stall) begin
            OUT_VALID <= r_sr_valid;
            if (r_sr_valid) begin
                Z       <= w_z_next;
`ifdef DSP_MAC_STREAM_OVF_EN
                ACC_OVF <= r_sr_ovf | (r_sr_sat & (w_hi | w_lo));
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_stream
// Brief    : Self-checking bench for dsp_mac_stream against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_stream;

    localparam int AW = 20;
    localparam int BW = 18;
    localparam int ACCW = 48;
    localparam int ZW = 38;
    localparam int SW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [AW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic          ua = 1'b0, ub = 1'b0, sub = 1'b0, first = 1'b0, last = 1'b0;
    logic [SW-1:0] shift_right = '0;
    logic          round_en = 1'b0, sat = 1'b0;
    logic [ZW-1:0] z;
    logic          acc_ovf;

    dsp_mac_stream dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .UNSIGNED_A(ua), .UNSIGNED_B(ub), .SUBTRACT(sub),
        .FIRST(first), .LAST(last), .SHIFT_RIGHT(shift_right), .ROUND(round_en),
        .SATURATE(sat), .OUT_VALID(out_valid), .OUT_READY(out_ready),
`ifdef DSP_MAC_STREAM_OVF_EN
        .ACC_OVF(acc_ovf),
`endif
        .Z(z)
    );
`ifndef DSP_MAC_STREAM_OVF_EN
    assign acc_ovf = 1'b0;
`endif

    int     checks = 0, failures = 0, cyc = 0, last_acc_cyc = 0;
    bit     rand_ready = 1'b0;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    longint exp_z[$], got_z[$];
    bit     exp_f[$], got_f[$];
    int     got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_z.push_back(longint'(z));
            got_f.push_back(acc_ovf);
            got_cyc.push_back(cyc);
        end
    end

    function automatic longint sext(input longint v, input int w);
        longint t;
        t = v & ((64'sd1 <<< w) - 1);
        if (t >= (64'sd1 <<< (w - 1))) t = t - (64'sd1 <<< w);
        return t;
    endfunction

    // Reference: plain integer arithmetic on the accepted beat's fields.
    task automatic model_accept();
        longint av, bv, base, raw, v, lo, hi;
        bit step, clamped;
        av = ua ? longint'(a) : sext(longint'(a), AW);
        bv = ub ? longint'(b) : sext(longint'(b), BW);
        base = first ? 64'sd0 : m_acc;
        raw = sub ? base - av * bv : base + av * bv;
        step = (raw < -(64'sd1 <<< (ACCW - 1))) || (raw >= (64'sd1 <<< (ACCW - 1)));
        m_ovf = (first ? 1'b0 : m_ovf) | step;
        m_acc = sext(raw, ACCW);
        if (last) begin
            if (round_en && shift_right != 0)
                v = (m_acc + (64'sd1 <<< (shift_right - 1))) >>> shift_right;
            else
                v = m_acc >>> shift_right;
            if (ua && ub) begin
                lo = 0;
                hi = (64'sd1 <<< ZW) - 1;
            end else begin
                lo = -(64'sd1 <<< (ZW - 1));
                hi = (64'sd1 <<< (ZW - 1)) - 1;
            end
            clamped = 1'b0;
            if (sat && v > hi) begin v = hi; clamped = 1'b1; end
            else if (sat && v < lo) begin v = lo; clamped = 1'b1; end
            exp_z.push_back(v & ((64'sd1 <<< ZW) - 1));
            exp_f.push_back(m_ovf | clamped);
        end
    endtask

    task automatic send_beat(input logic [AW-1:0] ta, input logic [BW-1:0] tb,
                             input bit tua, input bit tub, input bit tsub,
                             input bit tfirst, input bit tlast, input logic [SW-1:0] tsh,
                             input bit trnd, input bit tsat);
        bit rdy;
        int n;
        a = ta; b = tb; ua = tua; ub = tub; sub = tsub; first = tfirst; last = tlast;
        shift_right = tsh; round_en = trnd; sat = tsat; in_valid = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (rdy) begin
            model_accept();
            last_acc_cyc = cyc;
        end else begin
            checks++; failures++;
            $display("FAIL send_beat_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (got_z.size() < n && t < 400) begin
            @(posedge clk);
            #1;
            t++;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic clear_queues();
        exp_z.delete(); exp_f.delete(); got_z.delete(); got_f.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (z !== '0) begin failures++; $display("FAIL reset_z: got %0h want 0", z); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0; m_ovf = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_dot_product();
        clear_queues();
        out_ready = 1'b1;
        send_beat(AW'(-3), BW'(5), 0, 0, 0, 1, 0, 0, 0, 0);
        send_beat(AW'(7), BW'(2), 0, 0, 0, 0, 1, 0, 0, 0);
        wait_results(1);
        checks++;
        if (got_z.size() != 1) begin
            failures++; $display("FAIL dot_count: got %0d results want 1", got_z.size());
        end else begin
            checks++; if (got_z[0] !== 64'h3F_FFFF_FFFF) begin failures++; $display("FAIL dot_z: got %0h want 3fffffffff", got_z[0]); end
            checks++; if (got_z[0] !== exp_z[0]) begin failures++; $display("FAIL dot_model: got %0h want %0h", got_z[0], exp_z[0]); end
            checks++; if (got_cyc[0] - last_acc_cyc != 4) begin failures++; $display("FAIL dot_latency: got %0d want 4", got_cyc[0] - last_acc_cyc); end
        end
    endtask

    task automatic test_round();
        clear_queues();
        send_beat(AW'(10), BW'(1), 0, 0, 0, 1, 1, 2, 1, 0);
        send_beat(AW'(10), BW'(1), 0, 0, 0, 1, 1, 2, 0, 0);
        wait_results(2);
        checks++;
        if (got_z.size() != 2) begin
            failures++; $display("FAIL round_count: got %0d results want 2", got_z.size());
        end else begin
            checks++; if (got_z[0] !== 64'd3) begin failures++; $display("FAIL round_on: got %0d want 3", got_z[0]); end
            checks++; if (got_z[1] !== 64'd2) begin failures++; $display("FAIL round_off: got %0d want 2", got_z[1]); end
        end
    endtask

    task automatic test_saturation();
        clear_queues();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 4; i++)
                send_beat(20'h7FFFF, 18'h1FFFF, 0, 0, 0, i == 0, i == 3, 0, 0, g == 0);
        wait_results(2);
        checks++;
        if (got_z.size() != 2) begin
            failures++; $display("FAIL sat_count: got %0d results want 2", got_z.size());
        end else begin
            checks++; if (got_z[0] !== 64'h1F_FFFF_FFFF) begin failures++; $display("FAIL sat_clamp: got %0h want 1fffffffff", got_z[0]); end
            checks++; if (got_z[1] !== exp_z[1]) begin failures++; $display("FAIL sat_wrap: got %0h want %0h", got_z[1], exp_z[1]); end
`ifdef DSP_MAC_STREAM_OVF_EN
            checks++; if (got_f[0] !== 1'b1) begin failures++; $display("FAIL sat_ovf_on: got %0b want 1", got_f[0]); end
            checks++; if (got_f[1] !== 1'b0) begin failures++; $display("FAIL sat_ovf_off: got %0b want 0", got_f[1]); end
`endif
        end
    endtask

    task automatic test_unsigned();
        clear_queues();
        send_beat(20'hFFFFF, 18'h3FFFF, 1, 1, 0, 1, 1, 0, 0, 0);
        send_beat(20'hFFFFF, 18'h3FFFF, 1, 1, 1, 1, 1, 0, 0, 1);
        wait_results(2);
        checks++;
        if (got_z.size() != 2) begin
            failures++; $display("FAIL uns_count: got %0d results want 2", got_z.size());
        end else begin
            checks++; if (got_z[0] !== 64'h3F_FFEC_0001) begin failures++; $display("FAIL uns_prod: got %0h want 3fffec0001", got_z[0]); end
            checks++; if (got_z[1] !== 64'd0) begin failures++; $display("FAIL uns_sub_sat: got %0h want 0", got_z[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        clear_queues();
        out_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            send_beat(AW'($urandom), BW'($urandom), 0, 0, 0, 1, 0, 0, 0, 0);
            send_beat(AW'($urandom), BW'($urandom), 0, 0, 1, 0, 1, 3, 1, 0);
        end
        repeat (4) @(posedge clk);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || z !== exp_z[0][ZW-1:0]) stable = 1'b0;
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        checks++; if (!stable) begin failures++; $display("FAIL bp_hold: z=%0h valid=%0b want z=%0h held", z, out_valid, exp_z[0]); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_results(2);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_z.size() != 2) begin
            failures++; $display("FAIL bp_count: got %0d results want 2", got_z.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_z[i] !== exp_z[i]) begin failures++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, got_z[i], exp_z[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_group();
        clear_queues();
        out_ready = 1'b1;
        send_beat(AW'(100), BW'(1), 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0; m_ovf = 1'b0;
        clear_queues();
        send_beat(AW'(2), BW'(3), 0, 0, 0, 0, 1, 0, 0, 0);
        wait_results(1);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (got_z.size() != 1) begin
            failures++; $display("FAIL rst_mid_count: got %0d results want 1", got_z.size());
        end else begin
            checks++; if (got_z[0] !== 64'd6) begin failures++; $display("FAIL rst_mid_z: got %0d want 6", got_z[0]); end
        end
    endtask

    task automatic test_random();
        bit gua, gub, grnd, gsat;
        logic [SW-1:0] gsh;
        int len;
        clear_queues();
        rand_ready = 1'b1;
        for (int g = 0; g < 40; g++) begin
            gua = 1'($urandom_range(0, 1));
            gub = 1'($urandom_range(0, 1));
            grnd = 1'($urandom_range(0, 1));
            gsat = 1'($urandom_range(0, 1));
            gsh = ($urandom_range(0, 7) == 0) ? SW'($urandom) : SW'($urandom_range(0, 20));
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                send_beat(AW'($urandom), BW'($urandom), gua, gub, 1'($urandom_range(0, 1)),
                          (i == 0) && ($urandom_range(0, 7) != 0), i == len - 1, gsh, grnd, gsat);
                if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            end
        end
        wait_results(exp_z.size());
        rand_ready = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got_z.size() != exp_z.size()) begin
            failures++; $display("FAIL rand_count: got %0d results want %0d", got_z.size(), exp_z.size());
        end
        for (int i = 0; i < got_z.size() && i < exp_z.size(); i++) begin
            checks++;
            if (got_z[i] !== exp_z[i]) begin failures++; $display("FAIL rand_z[%0d]: got %0h want %0h", i, got_z[i], exp_z[i]); end
`ifdef DSP_MAC_STREAM_OVF_EN
            checks++;
            if (got_f[i] !== exp_f[i]) begin failures++; $display("FAIL rand_ovf[%0d]: got %0b want %0b", i, got_f[i], exp_f[i]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_dot_product();
        test_round();
        test_saturation();
        test_unsigned();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
